mips_multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and write-back over several clocks, one instruction at a time. It drives the 2-bit ALUOp consumed by the ALU control/ALU pair, plus every datapath mux select and write enable. It waits on a memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 68 ++++++
 rtl/mips_ctrl_decode.sv | 72 +++++++
 rtl/mips_multicycle_control.sv | 103 ++++++++++
 tb/tb_mips_multicycle_control.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM state
// numbering, ALUOp / ALU-B / PC-source select codes and the control bundle.
package mips_ctrl_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp codes, shared with the ALU control block
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // State numbering is visible on state_dbg, so values are pinned.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // Every datapath control produced from the state
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // True for the opcodes this controller knows how to sequence
    function automatic logic opcode_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure combinational map from FSM state (plus mem_ready for the fetch
// handshake) to the datapath control bundle. Unlisted controls are 0.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Moore decode; only the FETCH IR/PC loads look at mem_ready
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // speculative branch target into ALUOut
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: holds the state and the
// opcode latched in DECODE, computes the next state, and gates all outputs
// to 0 while reset is high so an aborted instruction issues no writes.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t     state_reg;
    state_t     state_next;
    logic [5:0] opcode_reg;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl_out;

    // State register and opcode latch (captured only while in DECODE)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_FETCH;
            opcode_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                opcode_reg <= opcode;
            end
        end
    end

    // Next-state: DECODE dispatches on the live opcode, MEM_ADDR on the latch
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_next = (opcode_reg == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_ADDI_EX:   state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state     (state_reg),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Reset is synchronous, so the old state is still present during the
    // reset cycle; mask everything so nothing is written in that cycle.
    assign ctrl_out = reset ? '0 : ctrl_raw;

    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign reg_dst       = ctrl_out.reg_dst;
    assign reg_write     = ctrl_out.reg_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign pc_source     = ctrl_out.pc_source;

    assign illegal_op = ~reset & (state_reg == S_DECODE) & ~opcode_supported(opcode);
    assign state_dbg  = reset ? 4'd0 : state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: each cycle drives reset,
// mem_ready and opcode, then checks state_dbg and the packed output vector
// against hand-written constants.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state_dbg     (state_dbg)
    );

    // Field order: pw pwc iod mr mw ir m2r rd rw asa asb[2] aop[2] psrc[2] ill
    logic [16:0] outs;
    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, illegal_op};

    localparam logic [16:0] O_ZERO      = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_FETCH_RDY = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_FETCH_WT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] O_DEC_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] O_MEM_ADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_MEM_READ  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_MEM_WB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] O_MEM_WRITE = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_EXECUTE   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] O_R_WB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] O_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] O_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] O_ADDI_WB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_BAD  = 6'b111111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, settle, check, then let
    // the rising edge advance the FSM.
    task automatic cyc(input string tag, input logic rst, input logic mr,
                       input logic [5:0] op, input logic [3:0] exp_state,
                       input logic [16:0] exp_outs);
        @(negedge clk);
        reset     = rst;
        mem_ready = mr;
        opcode    = op;
        #1;
        $display("txn %-12s rst=%0b rdy=%0b op=%06b state=%0d outs=%05h",
                 tag, rst, mr, op, state_dbg, outs);
        check({tag, "_state"}, 32'(state_dbg), 32'(exp_state));
        check({tag, "_outs"}, 32'(outs), 32'(exp_outs));
        @(posedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b0;

        // Reset held three cycles: everything 0
        cyc("rst0", 1, 1, OPC_R, 4'd0, O_ZERO);
        cyc("rst1", 1, 1, OPC_R, 4'd0, O_ZERO);
        cyc("rst2", 1, 1, OPC_R, 4'd0, O_ZERO);

        // R-type: 0,1,6,7
        cyc("r_fetch", 0, 1, OPC_R, 4'd0, O_FETCH_RDY);
        cyc("r_decode", 0, 1, OPC_R, 4'd1, O_DECODE);
        cyc("r_exec", 0, 1, OPC_BAD, 4'd6, O_EXECUTE);
        cyc("r_wb", 0, 1, OPC_BAD, 4'd7, O_R_WB);

        // lw with two wait cycles; opcode port changed after DECODE
        cyc("lw_fetch", 0, 1, OPC_LW, 4'd0, O_FETCH_RDY);
        cyc("lw_decode", 0, 1, OPC_LW, 4'd1, O_DECODE);
        cyc("lw_addr", 0, 1, OPC_SW, 4'd2, O_MEM_ADDR);
        cyc("lw_wait0", 0, 0, OPC_SW, 4'd3, O_MEM_READ);
        cyc("lw_wait1", 0, 0, OPC_SW, 4'd3, O_MEM_READ);
        cyc("lw_read", 0, 1, OPC_SW, 4'd3, O_MEM_READ);
        cyc("lw_wb", 0, 0, OPC_SW, 4'd4, O_MEM_WB);

        // beq, with one fetch wait cycle first
        cyc("beq_fwait", 0, 0, OPC_BEQ, 4'd0, O_FETCH_WT);
        cyc("beq_fetch", 0, 1, OPC_BEQ, 4'd0, O_FETCH_RDY);
        cyc("beq_decode", 0, 1, OPC_BEQ, 4'd1, O_DECODE);
        cyc("beq_branch", 0, 1, OPC_R, 4'd8, O_BRANCH);

        // j
        cyc("j_fetch", 0, 1, OPC_J, 4'd0, O_FETCH_RDY);
        cyc("j_decode", 0, 1, OPC_J, 4'd1, O_DECODE);
        cyc("j_jump", 0, 1, OPC_R, 4'd9, O_JUMP);

        // addi; mem_ready low in DECODE must not stall
        cyc("addi_fetch", 0, 1, OPC_ADDI, 4'd0, O_FETCH_RDY);
        cyc("addi_decode", 0, 0, OPC_ADDI, 4'd1, O_DECODE);
        cyc("addi_ex", 0, 1, OPC_R, 4'd10, O_MEM_ADDR);
        cyc("addi_wb", 0, 1, OPC_R, 4'd11, O_ADDI_WB);

        // Illegal opcode: one-cycle pulse then back to FETCH
        cyc("ill_fetch", 0, 1, OPC_BAD, 4'd0, O_FETCH_RDY);
        cyc("ill_decode", 0, 1, OPC_BAD, 4'd1, O_DEC_ILL);
        cyc("ill_after", 0, 0, OPC_BAD, 4'd0, O_FETCH_WT);

        // sw aborted by reset during the write wait
        cyc("swa_fetch", 0, 1, OPC_SW, 4'd0, O_FETCH_RDY);
        cyc("swa_decode", 0, 1, OPC_SW, 4'd1, O_DECODE);
        cyc("swa_addr", 0, 1, OPC_SW, 4'd2, O_MEM_ADDR);
        cyc("swa_wait", 0, 0, OPC_SW, 4'd5, O_MEM_WRITE);
        cyc("swa_reset", 1, 0, OPC_SW, 4'd0, O_ZERO);
        cyc("swa_refetch", 0, 0, OPC_SW, 4'd0, O_FETCH_WT);
        check("opcode_latch_cleared", 32'(dut.opcode_reg), 32'd0);

        // Full sw with mem_ready high: 4 cycles
        cyc("sw_fetch", 0, 1, OPC_SW, 4'd0, O_FETCH_RDY);
        cyc("sw_decode", 0, 1, OPC_SW, 4'd1, O_DECODE);
        cyc("sw_addr", 0, 1, OPC_LW, 4'd2, O_MEM_ADDR);
        cyc("sw_write", 0, 1, OPC_LW, 4'd5, O_MEM_WRITE);
        cyc("sw_done", 0, 0, OPC_LW, 4'd0, O_FETCH_WT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
